// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table: counter state encodings,
// reset state and the saturating two-bit step function.
// No logic of its own; imported by bp_sat_counter2 and branch_predictor_bht.
package bp_pkg;

    // Two-bit counter states. The MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BP_CNT_RESET = WNT;

    // One saturating step: toward ST on taken, toward SNT on not-taken.
    function automatic logic [1:0] bp_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            return (cnt == SNT) ? SNT : cnt - 2'd1;
        end
    endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// Purpose: one two-bit saturating counter entry of the branch history table.
// Latency: state updates on the clk edge where en is high; state is a flop output.
// Backpressure: none; every enabled edge applies. Ports: clk, rst (async, high),
//   en (apply step this edge), taken (step direction), state (current counter).
module bp_sat_counter2
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BP_CNT_RESET;
        end else if (en) begin
            state <= bp_next(state, taken);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Purpose: bimodal (optionally gshare, macro BP_GSHARE_EN) branch predictor with perf counters.
// Latency: lookup combinational; table/history update on the edge; mispredict registered (1 cycle).
// Backpressure: none; one update accepted every cycle, back-to-back same-index updates all apply.
// Ports: clk, rst (async, high) | if_pc -> pred_taken, pred_idx (fetch lookup)
//   upd_valid, upd_idx, upd_pred, upd_taken (resolved branch from EX)
//   mispredict, br_count, miss_count (status/performance outputs)
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int INDEX_BITS = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_W-1:0]       if_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_idx,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic                  upd_pred,
    input  logic                  upd_taken,
    output logic                  mispredict,
    output logic [CNT_W-1:0]      br_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] base_idx;
    logic [ENTRIES-1:0]    pred_bits;
    logic [ENTRIES-1:0]    state_lsbs;
    logic                  upd_miss;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign base_idx = if_pc[INDEX_BITS+1:2];
    assign upd_miss = upd_valid & (upd_taken ^ upd_pred);

    // Only the index bits of the PC and the counter MSBs feed the prediction.
    logic unused_bits;
    assign unused_bits = ^{if_pc[PC_W-1:INDEX_BITS+2], if_pc[1:0], state_lsbs};

`ifdef BP_GSHARE_EN
    // Global history is updated only from resolved outcomes, never speculatively.
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[INDEX_BITS-2:0], upd_taken};
        end
    end

    assign pred_idx = base_idx ^ ghr;
`else
    assign pred_idx = base_idx;
`endif

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic [1:0] state;

        bp_sat_counter2 u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (upd_valid && (upd_idx == INDEX_BITS'(i))),
            .taken (upd_taken),
            .state (state)
        );

        assign pred_bits[i]  = state[1];
        assign state_lsbs[i] = state[0];
    end

    // Reads the flop outputs directly: a same-cycle update is seen only next cycle.
    assign pred_taken = pred_bits[pred_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict <= 1'b0;
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            mispredict <= upd_miss;
            if (upd_valid) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (upd_miss) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [4:0]  pred_idx;
    logic        upd_valid;
    logic [4:0]  upd_idx;
    logic        upd_pred;
    logic        upd_taken;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    // Reference state: counter value per entry as a plain integer 0..3,
    // history as an integer, counts as integers.
    int          mdl_tbl [32];
    int          mdl_ghr;
    int unsigned mdl_br;
    int unsigned mdl_miss;

    typedef struct {
        logic        vld;
        logic [4:0]  idx;
        logic        pred;
        logic        taken;
        logic [31:0] pc;
        logic        exp_taken;
        logic        exp_misp;
        int unsigned exp_br;
        int unsigned exp_miss;
    } vec_t;

    vec_t vecs[$];

    branch_predictor_bht dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_pred   (upd_pred),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .br_count   (br_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] i, input logic p, input logic t,
                         input logic [31:0] pc);
        upd_valid = v;
        upd_idx   = i;
        upd_pred  = p;
        upd_taken = t;
        if_pc     = pc;
    endtask

    function automatic int model_index(input logic [31:0] pc);
        int base;
        base = (pc / 4) % 32;
`ifdef BP_GSHARE_EN
        return base ^ mdl_ghr;
`else
        return base;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_tbl[i] = 1;
        mdl_ghr  = 0;
        mdl_br   = 0;
        mdl_miss = 0;
    endtask

    task automatic model_update(input logic v, input logic [4:0] i, input logic p, input logic t);
        if (v) begin
            if (t) mdl_tbl[i] = (mdl_tbl[i] == 3) ? 3 : mdl_tbl[i] + 1;
            else   mdl_tbl[i] = (mdl_tbl[i] == 0) ? 0 : mdl_tbl[i] - 1;
            mdl_ghr = ((mdl_ghr * 2) + (t ? 1 : 0)) % 32;
            mdl_br++;
            if (t != p) mdl_miss++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h40);
        model_reset();

        // Counter walks: idx 16 via PC 0x40, idx 3 via 0x0C, idx 7 via 0x1C.
        // Starting from WNT a single taken update already reaches WT (MSB 1).
        vecs.push_back('{1'b1, 5'd16, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 5'd16, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 2, 2});
        vecs.push_back('{1'b0, 5'd16, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 2, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 3, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 4, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 5, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 6, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 7, 2});
        vecs.push_back('{1'b1, 5'd3,  1'b1, 1'b0, 32'h0C, 1'b1, 1'b1, 8, 3});
        vecs.push_back('{1'b1, 5'd7,  1'b0, 1'b1, 32'h1C, 1'b1, 1'b1, 9, 4});
        vecs.push_back('{1'b1, 5'd7,  1'b1, 1'b1, 32'h1C, 1'b1, 1'b0, 10, 4});
        vecs.push_back('{1'b1, 5'd7,  1'b1, 1'b0, 32'h1C, 1'b1, 1'b1, 11, 5});
        vecs.push_back('{1'b1, 5'd7,  1'b1, 1'b0, 32'h1C, 1'b0, 1'b1, 12, 6});
        vecs.push_back('{1'b1, 5'd7,  1'b0, 1'b0, 32'h1C, 1'b0, 1'b0, 13, 6});
        vecs.push_back('{1'b1, 5'd7,  1'b0, 1'b0, 32'h1C, 1'b0, 1'b0, 14, 6});
        vecs.push_back('{1'b1, 5'd7,  1'b0, 1'b1, 32'h1C, 1'b0, 1'b1, 15, 7});

        #2;
        check("reset_pred_taken", pred_taken, 0);
        check("reset_mispredict", mispredict, 0);
        #10 rst = 1'b0;
        #1;
        check("reset_pred_idx_0x40", pred_idx, 16);
        check("reset_pred_taken_0x40", pred_taken, 0);
        check("reset_br_count", br_count, 0);
        check("reset_miss_count", miss_count, 0);
        tick();

`ifndef BP_GSHARE_EN
        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].vld, vecs[n].idx, vecs[n].pred, vecs[n].taken, vecs[n].pc);
            tick();
            upd_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_pred_idx", n), pred_idx, (vecs[n].pc / 4) % 32);
            check($sformatf("vec%0d_pred_taken", n), pred_taken, vecs[n].exp_taken);
            check($sformatf("vec%0d_mispredict", n), mispredict, vecs[n].exp_misp);
            check($sformatf("vec%0d_br_count", n), br_count, vecs[n].exp_br);
            check($sformatf("vec%0d_miss_count", n), miss_count, vecs[n].exp_miss);
        end

        // Entry 7 sits at WNT: a same-cycle lookup must still see the old value.
        drive(1'b1, 5'd7, 1'b0, 1'b1, 32'h1C);
        #1;
        check("same_cycle_old_value", pred_taken, 0);
        tick();
        upd_valid = 1'b0;
        #1;
        check("same_cycle_new_value", pred_taken, 1);
        check("idle_pulse_cleared_next", mispredict, 1);
        tick();
        check("mispredict_one_cycle", mispredict, 0);
`else
        // History after T, T, N is 5'b00110.
        drive(1'b1, 5'd0, 1'b0, 1'b1, 32'h40);
        tick();
        drive(1'b1, 5'd1, 1'b0, 1'b1, 32'h40);
        tick();
        drive(1'b1, 5'd2, 1'b0, 1'b0, 32'h40);
        tick();
        upd_valid = 1'b0;
        #1;
        check("gshare_pred_idx", pred_idx, 22);
        check("gshare_br_count", br_count, 3);
`endif

        // Saturate entry 16 and leave a mispredict pending, then reset between edges.
        drive(1'b1, 5'd16, 1'b0, 1'b1, 32'h40);
        tick();
        drive(1'b1, 5'd16, 1'b0, 1'b1, 32'h40);
        tick();
        upd_valid = 1'b0;
        #1;
        check("pre_reset_mispredict", mispredict, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_mispredict", mispredict, 0);
        check("async_reset_br_count", br_count, 0);
        check("async_reset_miss_count", miss_count, 0);
        check("async_reset_pred_0x40", pred_taken, 0);
        #3 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check($sformatf("post_reset_entry%0d", i), pred_taken, 0);
        end
        tick();

        // Randomized traffic against the reference model; idx range kept small
        // so entries hit both saturation ends and same-index back-to-back updates.
        for (int n = 0; n < 600; n++) begin
            logic        v;
            logic [4:0]  i;
            logic        p;
            logic        t;
            logic [31:0] pc;
            int          mi;
            v  = ($urandom_range(0, 3) != 0);
            i  = 5'($urandom_range(0, 7));
            p  = 1'($urandom);
            t  = ($urandom_range(0, 2) != 0);
            pc = (n % 2 == 0) ? 32'($urandom_range(0, 7) * 4) : $urandom;
            drive(v, i, p, t, pc);
            #1;
            mi = model_index(pc);
            check("rand_pred_idx", pred_idx, mi);
            check("rand_pred_taken", pred_taken, (mdl_tbl[mi] >= 2) ? 1 : 0);
            tick();
            model_update(v, i, p, t);
            check("rand_mispredict", mispredict, (v && (t != p)) ? 1 : 0);
            check("rand_br_count", br_count, mdl_br);
            check("rand_miss_count", miss_count, mdl_miss);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
